// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter between the fetch (I) and load/store (D) ports.
// Every access is sequenced IDLE -> ACCESS -> [WAIT] -> DONE with a one-cycle ready pulse.
module mem_arbiter #(
  parameter int unsigned ADDR_W     = 10,
  parameter int unsigned RAM_LAT    = 1,
  parameter int unsigned STARVE_LIM = 4
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              i_req,
  input  logic [31:0]       i_addr,
  output logic [31:0]       i_rdata,
  output logic              i_ready,
  input  logic              d_ren,
  input  logic              d_wen,
  input  logic [31:0]       d_addr,
  input  logic [31:0]       d_wdata,
  output logic [31:0]       d_rdata,
  output logic              d_ready,
  output logic              d_err,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_wen,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata,
  output logic              busy
);

  localparam int unsigned CNT_W = $clog2(RAM_LAT + 1);
  localparam int unsigned STK_W = $clog2(STARVE_LIM + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_WAIT,
    S_DONE
  } state_t;

  state_t            r_state;
  state_t            w_next;

  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata;
  logic              r_is_d;
  logic              r_write;
  logic              r_err;
  logic [CNT_W-1:0]  r_cnt;
  logic [STK_W-1:0]  r_streak;
  logic [31:0]       r_i_rdata;
  logic [31:0]       r_d_rdata;

  logic              w_d_req;
  logic              w_d_bad;
  logic              w_force_i;
  logic              w_grant_d;
  logic              w_grant_i;
  logic              w_last_wait;
  logic              w_unused_addr;

  assign w_d_req     = d_ren | d_wen;
  assign w_d_bad     = (d_ren & d_wen) | (d_addr[1:0] != 2'b00);
  assign w_force_i   = i_req && (r_streak == STK_W'(STARVE_LIM));
  assign w_grant_d   = w_d_req && !w_force_i;
  assign w_grant_i   = i_req && !w_grant_d;
  assign w_last_wait = (r_cnt == CNT_W'(1));

  // Byte-offset and above-RAM address bits are intentionally discarded (RAM wraps).
  assign w_unused_addr = ^{i_addr[31:ADDR_W+2], i_addr[1:0], d_addr[31:ADDR_W+2]};

  always_comb begin
    w_next    = r_state;
    busy      = (r_state != S_IDLE);
    ram_addr  = r_addr;
    ram_wen   = 1'b0;
    ram_wdata = '0;
    i_ready   = 1'b0;
    d_ready   = 1'b0;
    d_err     = 1'b0;
    i_rdata   = r_i_rdata;
    d_rdata   = r_d_rdata;
    case (r_state)
      S_IDLE: begin
        if (w_grant_d) begin
          w_next = w_d_bad ? S_DONE : S_ACCESS;
        end else if (w_grant_i) begin
          w_next = S_ACCESS;
        end
      end
      S_ACCESS: begin
        ram_wen   = r_write;
        ram_wdata = r_write ? r_wdata : '0;
        w_next    = r_write ? S_DONE : S_WAIT;
      end
      S_WAIT: begin
        if (w_last_wait) begin
          w_next = S_DONE;
        end
      end
      S_DONE: begin
        i_ready = !r_is_d;
        d_ready = r_is_d;
        d_err   = r_is_d && r_err;
        w_next  = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_state   <= S_IDLE;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_is_d    <= 1'b0;
      r_write   <= 1'b0;
      r_err     <= 1'b0;
      r_cnt     <= '0;
      r_streak  <= '0;
      r_i_rdata <= '0;
      r_d_rdata <= '0;
    end else begin
      r_state <= w_next;
      case (r_state)
        S_IDLE: begin
          if (w_grant_d) begin
            r_is_d  <= 1'b1;
            r_write <= d_wen;
            r_err   <= w_d_bad;
            r_addr  <= d_addr[ADDR_W+1:2];
            r_wdata <= d_wdata;
            // A rejected request never touches the RAM, so it does not count towards starvation.
            if (!w_d_bad) begin
              r_streak <= i_req ? r_streak + STK_W'(1) : '0;
            end
          end else if (w_grant_i) begin
            r_is_d   <= 1'b0;
            r_write  <= 1'b0;
            r_err    <= 1'b0;
            r_addr   <= i_addr[ADDR_W+1:2];
            r_streak <= '0;
          end
        end
        S_ACCESS: r_cnt <= CNT_W'(RAM_LAT);
        S_WAIT: begin
          r_cnt <= r_cnt - CNT_W'(1);
          if (w_last_wait) begin
            if (r_is_d) begin
              r_d_rdata <= ram_rdata;
            end else begin
              r_i_rdata <= ram_rdata;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: instance A (RAM_LAT=1) takes randomized traffic against a
// transaction-level model; instance B (RAM_LAT=3) covers long latency and mid-access reset.
module tb_mem_arbiter;

  localparam int unsigned AW    = 10;
  localparam int unsigned LAT_A = 1;
  localparam int unsigned LAT_B = 3;
  localparam int unsigned SL    = 4;

  typedef struct {
    logic        ren;
    logic        wen;
    logic [31:0] addr;
    logic [31:0] wdata;
  } txn_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          nrst_a, i_req_a, i_ready_a, d_ren_a, d_wen_a, d_ready_a, d_err_a, ram_wen_a, busy_a;
  logic [31:0]   i_addr_a, i_rdata_a, d_addr_a, d_wdata_a, d_rdata_a, ram_wdata_a, ram_rdata_a;
  logic [AW-1:0] ram_addr_a;

  logic          nrst_b, i_req_b, i_ready_b, d_ren_b, d_wen_b, d_ready_b, d_err_b, ram_wen_b, busy_b;
  logic [31:0]   i_addr_b, i_rdata_b, d_addr_b, d_wdata_b, d_rdata_b, ram_wdata_b, ram_rdata_b;
  logic [AW-1:0] ram_addr_b;

  mem_arbiter #(.ADDR_W(AW), .RAM_LAT(LAT_A), .STARVE_LIM(SL)) u_dut_a (
    .clk(clk), .nrst(nrst_a),
    .i_req(i_req_a), .i_addr(i_addr_a), .i_rdata(i_rdata_a), .i_ready(i_ready_a),
    .d_ren(d_ren_a), .d_wen(d_wen_a), .d_addr(d_addr_a), .d_wdata(d_wdata_a),
    .d_rdata(d_rdata_a), .d_ready(d_ready_a), .d_err(d_err_a),
    .ram_addr(ram_addr_a), .ram_wen(ram_wen_a), .ram_wdata(ram_wdata_a), .ram_rdata(ram_rdata_a),
    .busy(busy_a)
  );

  mem_arbiter #(.ADDR_W(AW), .RAM_LAT(LAT_B), .STARVE_LIM(SL)) u_dut_b (
    .clk(clk), .nrst(nrst_b),
    .i_req(i_req_b), .i_addr(i_addr_b), .i_rdata(i_rdata_b), .i_ready(i_ready_b),
    .d_ren(d_ren_b), .d_wen(d_wen_b), .d_addr(d_addr_b), .d_wdata(d_wdata_b),
    .d_rdata(d_rdata_b), .d_ready(d_ready_b), .d_err(d_err_b),
    .ram_addr(ram_addr_b), .ram_wen(ram_wen_b), .ram_wdata(ram_wdata_b), .ram_rdata(ram_rdata_b),
    .busy(busy_b)
  );

  // RAM models: A has one cycle of read latency, B three.
  logic [31:0] mem_a [0:1023];
  logic [31:0] mem_b [0:1023];
  logic [31:0] pipe_a;
  logic [31:0] pipe_b [0:2];
  logic        preload;
  logic [31:0] seed;

  function automatic logic [31:0] init_word(input int unsigned idx, input logic [31:0] s);
    return 32'(idx * 32'h9E3779B1) ^ s;
  endfunction

  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 1024; i++) begin
        mem_a[i] <= init_word(i, seed);
        mem_b[i] <= init_word(i, ~seed);
      end
    end else if (ram_wen_a) begin
      mem_a[ram_addr_a] <= ram_wdata_a;
    end
    pipe_a    <= mem_a[ram_addr_a];
    pipe_b[0] <= mem_b[ram_addr_b];
    pipe_b[1] <= pipe_b[0];
    pipe_b[2] <= pipe_b[1];
  end
  assign ram_rdata_a = pipe_a;
  assign ram_rdata_b = pipe_b[2];

  int unsigned wen_seen = 0;
  always @(negedge clk) if (ram_wen_a === 1'b1) wen_seen <= wen_seen + 1;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  int unsigned m_streak = 0;
  int unsigned wr_expected = 0;
  logic [31:0] ref_mem [0:1023];
  txn_t        iq[$];
  txn_t        dq[$];

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic txn_t mk(input logic ren, input logic wen, input logic [31:0] addr,
                              input logic [31:0] wdata);
    txn_t t;
    t.ren = ren; t.wen = wen; t.addr = addr; t.wdata = wdata;
    return t;
  endfunction

  task automatic present();
    if (iq.size() > 0) begin
      i_req_a = 1'b1; i_addr_a = iq[0].addr;
    end else begin
      i_req_a = 1'b0; i_addr_a = $urandom;
    end
    if (dq.size() > 0) begin
      d_ren_a = dq[0].ren; d_wen_a = dq[0].wen; d_addr_a = dq[0].addr; d_wdata_a = dq[0].wdata;
    end else begin
      d_ren_a = 1'b0; d_wen_a = 1'b0; d_addr_a = $urandom; d_wdata_a = $urandom;
    end
  endtask

  // Drains iq/dq with both requesters always presenting their next item; predicts
  // the grant from the starvation rule and the timing from per-operation latency.
  task automatic run_engine(input string tag);
    txn_t        t;
    bit          pick_d, rej, wr;
    int unsigned lat;
    logic [9:0]  w;
    logic [31:0] exp_rd;
    @(negedge clk);
    present();
    while (iq.size() > 0 || dq.size() > 0) begin
      chk($sformatf("%s_idle_busy", tag), 128'(busy_a), 128'(0));
      if (dq.size() == 0)      pick_d = 1'b0;
      else if (iq.size() == 0) pick_d = 1'b1;
      else                     pick_d = (m_streak != SL);
      t      = pick_d ? dq[0] : iq[0];
      rej    = pick_d && ((t.ren && t.wen) || (t.addr[1:0] != 2'b00));
      wr     = pick_d && !rej && t.wen;
      w      = t.addr[11:2];
      lat    = rej ? 1 : (wr ? 2 : LAT_A + 2);
      exp_rd = ref_mem[w];
      for (int unsigned n = 1; n <= lat; n++) begin
        @(negedge clk);
        if (n == 1 && !rej) begin
          chk($sformatf("%s_ram_addr", tag), 128'(ram_addr_a), 128'(w));
          chk($sformatf("%s_ram_wen", tag), 128'(ram_wen_a), 128'(wr));
          if (wr) chk($sformatf("%s_ram_wdata", tag), 128'(ram_wdata_a), 128'(t.wdata));
        end
        if (n < lat) begin
          chk($sformatf("%s_wait_c%0d", tag, n), 128'({busy_a, i_ready_a, d_ready_a, d_err_a}),
              128'(4'b1000));
        end else begin
          chk($sformatf("%s_done_port", tag), 128'({busy_a, i_ready_a, d_ready_a, d_err_a}),
              128'({1'b1, !pick_d, pick_d, rej}));
          if (!pick_d) chk($sformatf("%s_i_rdata", tag), 128'(i_rdata_a), 128'(exp_rd));
          else if (!rej && !wr) chk($sformatf("%s_d_rdata", tag), 128'(d_rdata_a), 128'(exp_rd));
        end
        // In-flight transactions must ignore dropped requests and address changes.
        if (n == 1) begin
          if (pick_d) begin
            if ($urandom_range(0, 3) == 0) begin d_ren_a = 1'b0; d_wen_a = 1'b0; end
            else begin d_addr_a = $urandom; d_wdata_a = $urandom; end
          end else begin
            if ($urandom_range(0, 3) == 0) i_req_a = 1'b0;
            else i_addr_a = $urandom;
          end
        end
      end
      if (pick_d) begin
        if (!rej) m_streak = (iq.size() > 0) ? m_streak + 1 : 0;
        void'(dq.pop_front());
      end else begin
        m_streak = 0;
        void'(iq.pop_front());
      end
      if (wr) begin
        ref_mem[w] = t.wdata;
        wr_expected++;
      end
      present();
      @(negedge clk);
    end
  endtask

  initial begin
    logic [31:0] a;
    int unsigned r;
    seed = $urandom;
    for (int i = 0; i < 1024; i++) ref_mem[i] = init_word(i, seed);
    preload = 1'b1;
    nrst_a = 1'b0; nrst_b = 1'b0;
    i_req_a = 1'b0; i_addr_a = '0; d_ren_a = 1'b0; d_wen_a = 1'b0; d_addr_a = '0; d_wdata_a = '0;
    i_req_b = 1'b0; i_addr_b = '0; d_ren_b = 1'b0; d_wen_b = 1'b0; d_addr_b = '0; d_wdata_b = '0;

    repeat (2) @(negedge clk);
    chk("reset_a", {busy_a, ram_wen_a, i_ready_a, d_ready_a, d_err_a, ram_addr_a, i_rdata_a,
                    d_rdata_a, ram_wdata_a}, '0);
    chk("reset_b", {busy_b, ram_wen_b, i_ready_b, d_ready_b, d_err_b, ram_addr_b, i_rdata_b,
                    d_rdata_b, ram_wdata_b}, '0);
    preload = 1'b0;
    @(negedge clk);
    nrst_a = 1'b1; nrst_b = 1'b1;

    // Fetch only
    iq.push_back(mk(1'b0, 1'b0, 32'h8, '0));
    run_engine("t1");

    // Simultaneous fetch and store: store wins, fetch follows, data reads back
    dq.push_back(mk(1'b0, 1'b1, 32'h10, 32'hDEADBEEF));
    iq.push_back(mk(1'b0, 1'b0, 32'h4, '0));
    run_engine("t2");
    dq.push_back(mk(1'b1, 1'b0, 32'h10, '0));
    run_engine("t2rd");
    chk("t2_readback_hold", 128'(d_rdata_a), 128'(32'hDEADBEEF));

    // Rejects: misaligned load, both enables on an aligned address
    dq.push_back(mk(1'b1, 1'b0, 32'h13, '0));
    dq.push_back(mk(1'b1, 1'b1, 32'h40, 32'h1234_5678));
    run_engine("t4");

    // Starvation: both held, fetch every fifth grant
    for (int i = 0; i < 8; i++) dq.push_back(mk(1'b1, 1'b0, 32'($urandom_range(0, 15)) << 2, '0));
    for (int i = 0; i < 2; i++) iq.push_back(mk(1'b0, 1'b0, 32'($urandom_range(0, 15)) << 2, '0));
    run_engine("t3");

    // Randomized mix including wrap-around addresses and rejects
    for (int i = 0; i < 12; i++) iq.push_back(mk(1'b0, 1'b0, $urandom & 32'hFFFF_F03C, '0));
    for (int i = 0; i < 30; i++) begin
      r = $urandom_range(0, 9);
      a = $urandom & 32'hFFFF_F03C;
      if (r < 5)       dq.push_back(mk(1'b0, 1'b1, a, $urandom));
      else if (r < 8)  dq.push_back(mk(1'b1, 1'b0, a, $urandom));
      else if (r == 8) dq.push_back(mk(1'b1, 1'b0, a | 32'($urandom_range(1, 3)), '0));
      else             dq.push_back(mk(1'b1, 1'b1, a, $urandom));
    end
    run_engine("rnd");
    chk("wen_count", 128'(wen_seen), 128'(wr_expected));

    // Long latency load on instance B
    @(negedge clk);
    d_ren_b = 1'b1; d_addr_b = 32'h20;
    for (int unsigned n = 1; n <= 5; n++) begin
      @(negedge clk);
      chk($sformatf("t5_c%0d", n), 128'({busy_b, d_ready_b, i_ready_b}), 128'({1'b1, n == 5, 1'b0}));
      if (n == 5) chk("t5_rdata", 128'(d_rdata_b), 128'(init_word(8, ~seed)));
    end
    d_ren_b = 1'b0;
    @(negedge clk);
    chk("t5_idle", 128'(busy_b), 128'(0));

    // Reset during WAIT aborts the load, then a fetch runs normally
    d_ren_b = 1'b1; d_addr_b = 32'h24;
    repeat (2) @(negedge clk);
    chk("t6_in_wait", 128'(busy_b), 128'(1));
    nrst_b = 1'b0;
    #1;
    chk("t6_reset_now", {busy_b, ram_wen_b, i_ready_b, d_ready_b, d_err_b, ram_addr_b, i_rdata_b,
                         d_rdata_b, ram_wdata_b}, '0);
    d_ren_b = 1'b0;
    repeat (2) begin
      @(negedge clk);
      chk("t6_held", 128'({busy_b, d_ready_b, i_ready_b}), 128'(0));
    end
    nrst_b = 1'b1;
    @(negedge clk);
    i_req_b = 1'b1; i_addr_b = 32'hC;
    for (int unsigned n = 1; n <= 5; n++) begin
      @(negedge clk);
      chk($sformatf("t6_fetch_c%0d", n), 128'({busy_b, i_ready_b, d_ready_b}),
          128'({1'b1, n == 5, 1'b0}));
      if (n == 5) chk("t6_fetch_rdata", 128'(i_rdata_b), 128'(init_word(3, ~seed)));
    end
    i_req_b = 1'b0;
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
